// File: rtl/note_step_counter.sv
// note_step_counter: steps a note index through 0..M-1 at a programmable
// rate for the note ROM of the music-note player. A single-clock-domain
// prescaler produces the step strobe; four sweep modes decide where the
// index goes next and when the end-of-sequence strobe fires.
module note_step_counter #(
    parameter int N       = 8,
    parameter int M       = 149,
    parameter int CLK_DIV = 12500000,
    parameter int PW      = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic         restart,
    output logic [N-1:0] count,
    output logic         step_tick,
    output logic         complete_tick,
    output logic         running
);

    typedef enum logic [1:0] {
        MODE_LOOP_UP   = 2'b00,
        MODE_LOOP_DOWN = 2'b01,
        MODE_ONE_SHOT  = 2'b10,
        MODE_PING_PONG = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Index boundaries, all held at the count width so every compare is N bits.
    localparam logic [N-1:0] LAST_IDX    = N'(M - 1);
    localparam logic [N-1:0] BEFORE_LAST = N'(M - 2);
    localparam logic [N-1:0] IDX_ONE     = N'(1);

    // Prescaler terminal value and increment at the prescaler width.
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    mode_e          modeSel;
    logic           advance;
    logic           stepStrobe;

    logic [PW-1:0]  prescale_q, prescale_d;
    logic [N-1:0]   count_q, count_d;
    dir_e           dir_q, dir_d;
    logic           running_q, running_d;
    logic           stepTick_q, stepTick_d;
    logic           completeTick_q, completeTick_d;

    // Candidate results of a step, computed from the current index and mode.
    logic [N-1:0]   stepCount;
    dir_e           stepDir;
    logic           stepComplete;
    logic           stepStop;

    assign modeSel    = mode_e'(mode);
    assign advance    = enable & running_q;
    assign stepStrobe = advance & (prescale_q == PRE_LAST);

    // Where the index goes on the next step for the currently selected mode.
    always_comb begin
        stepCount    = count_q;
        stepDir      = dir_q;
        stepComplete = 1'b0;
        stepStop     = 1'b0;
        case (modeSel)
            MODE_LOOP_UP: begin
                if (count_q == LAST_IDX) begin
                    stepCount    = '0;
                    stepComplete = 1'b1;
                end else begin
                    stepCount = count_q + IDX_ONE;
                end
            end
            MODE_LOOP_DOWN: begin
                if (count_q == '0) begin
                    stepCount    = LAST_IDX;
                    stepComplete = 1'b1;
                end else begin
                    stepCount = count_q - IDX_ONE;
                end
            end
            MODE_ONE_SHOT: begin
                // Arriving at the last index ends the run; if a mode switch
                // lands us here already at the last index, stop in place
                // rather than stepping outside the valid range.
                if ((count_q == BEFORE_LAST) || (count_q == LAST_IDX)) begin
                    stepCount    = LAST_IDX;
                    stepComplete = 1'b1;
                    stepStop     = 1'b1;
                end else begin
                    stepCount = count_q + IDX_ONE;
                end
            end
            MODE_PING_PONG: begin
                if (dir_q == DIR_UP) begin
                    if (count_q == LAST_IDX) begin
                        stepCount = BEFORE_LAST;
                        stepDir   = DIR_DOWN;
                    end else begin
                        stepCount = count_q + IDX_ONE;
                    end
                end else begin
                    if (count_q == '0) begin
                        stepCount = IDX_ONE;
                        stepDir   = DIR_UP;
                    end else begin
                        stepCount = count_q - IDX_ONE;
                    end
                end
                stepComplete = (stepCount == '0);
            end
            default: begin
                stepCount = count_q;
            end
        endcase
    end

    // Next-state selection: restart beats everything, then a step, then plain prescaling.
    always_comb begin
        prescale_d     = prescale_q;
        count_d        = count_q;
        dir_d          = dir_q;
        running_d      = running_q;
        stepTick_d     = 1'b0;
        completeTick_d = 1'b0;
        if (restart) begin
            count_d    = (modeSel == MODE_LOOP_DOWN) ? LAST_IDX : '0;
            prescale_d = '0;
            dir_d      = DIR_UP;
            running_d  = 1'b1;
        end else if (stepStrobe) begin
            prescale_d     = '0;
            count_d        = stepCount;
            dir_d          = stepDir;
            stepTick_d     = 1'b1;
            completeTick_d = stepComplete;
            if (stepStop) begin
                running_d = 1'b0;
            end
        end else if (advance) begin
            prescale_d = prescale_q + PRE_ONE;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q     <= '0;
            count_q        <= '0;
            dir_q          <= DIR_UP;
            running_q      <= 1'b1;
            stepTick_q     <= 1'b0;
            completeTick_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            count_q        <= count_d;
            dir_q          <= dir_d;
            running_q      <= running_d;
            stepTick_q     <= stepTick_d;
            completeTick_q <= completeTick_d;
        end
    end

    assign count         = count_q;
    assign step_tick     = stepTick_q;
    assign complete_tick = completeTick_q;
    assign running       = running_q;

endmodule

// File: tb/tb_note_step_counter.sv
// Testbench for note_step_counter: directed scenarios followed by a random
// phase, every cycle compared against a behavioural model of the step rules.
module tb_note_step_counter;

    localparam int N       = 4;
    localparam int M       = 5;
    localparam int CLK_DIV = 4;
    localparam int PW      = 4;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         enable  = 1'b0;
    logic         restart = 1'b0;
    logic [1:0]   mode    = 2'b00;
    logic [N-1:0] count;
    logic         step_tick;
    logic         complete_tick;
    logic         running;

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model state.
    int mCount;
    int mPre;
    bit mUp;
    bit mRun;
    bit mStep;
    bit mDone;

    note_step_counter #(.N(N), .M(M), .CLK_DIV(CLK_DIV), .PW(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mode          (mode),
        .restart       (restart),
        .count         (count),
        .step_tick     (step_tick),
        .complete_tick (complete_tick),
        .running       (running)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        checkCount++;
        if (observed !== 32'(expected)) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mCount = 0;
        mPre   = 0;
        mUp    = 1'b1;
        mRun   = 1'b1;
        mStep  = 1'b0;
        mDone  = 1'b0;
    endtask

    // One step of the sequence, expressed with plain modular arithmetic.
    task automatic modelStep();
        mStep = 1'b1;
        case (mode)
            2'd0: begin
                mCount = (mCount + 1) % M;
                mDone  = (mCount == 0);
            end
            2'd1: begin
                mCount = (mCount + M - 1) % M;
                mDone  = (mCount == M - 1);
            end
            2'd2: begin
                if (mCount + 1 >= M - 1) begin
                    mCount = M - 1;
                    mDone  = 1'b1;
                    mRun   = 1'b0;
                end else begin
                    mCount = mCount + 1;
                end
            end
            default: begin
                if (mUp) begin
                    if (mCount == M - 1) begin
                        mUp    = 1'b0;
                        mCount = mCount - 1;
                    end else begin
                        mCount = mCount + 1;
                    end
                end else begin
                    if (mCount == 0) begin
                        mUp    = 1'b1;
                        mCount = 1;
                    end else begin
                        mCount = mCount - 1;
                    end
                end
                mDone = (mCount == 0);
            end
        endcase
    endtask

    task automatic modelClock();
        if (!reset) begin
            modelReset();
        end else if (restart) begin
            mCount = (mode == 2'd1) ? M - 1 : 0;
            mPre   = 0;
            mUp    = 1'b1;
            mRun   = 1'b1;
            mStep  = 1'b0;
            mDone  = 1'b0;
        end else begin
            mStep = 1'b0;
            mDone = 1'b0;
            if (enable && mRun) begin
                mPre++;
                if (mPre == CLK_DIV) begin
                    mPre = 0;
                    modelStep();
                end
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".count"},    32'(count),         mCount);
        checkOutput({tag, ".step"},     32'(step_tick),     int'(mStep));
        checkOutput({tag, ".complete"}, 32'(complete_tick), int'(mDone));
        checkOutput({tag, ".running"},  32'(running),       int'(mRun));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelClock();
        #1;
        compareAll(tag);
    endtask

    task automatic applyStimulus(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick(tag);
        end
    endtask

    task automatic pulseRestart(input logic [1:0] newMode);
        mode    = newMode;
        restart = 1'b1;
        tick("restart");
        restart = 1'b0;
    endtask

    initial begin
        int guard;
        logic [N-1:0] frozen;

        // Reset state.
        reset  = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkOutput("resetCount",    32'(count),         0);
        checkOutput("resetRunning",  32'(running),       1);
        checkOutput("resetStep",     32'(step_tick),     0);
        checkOutput("resetComplete", 32'(complete_tick), 0);

        // Loop up: first step after CLK_DIV cycles, wrap at cycle 20.
        reset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick("loopUp");
            if (c == 4) checkOutput("firstStepCount", 32'(count), 1);
            if (c == 3) checkOutput("noEarlyStep", 32'(step_tick), 0);
            if (c == 20) begin
                checkOutput("wrapCount",    32'(count),         0);
                checkOutput("wrapComplete", 32'(complete_tick), 1);
            end
        end

        // One-shot up, then a long hold, then restart.
        pulseRestart(2'b10);
        applyStimulus(16, "oneShot");
        checkOutput("oneShotEndCount",   32'(count),   M - 1);
        checkOutput("oneShotEndRunning", 32'(running), 0);
        applyStimulus(40, "oneShotHold");
        pulseRestart(2'b10);
        checkOutput("oneShotRestartCount",   32'(count),   0);
        checkOutput("oneShotRestartRunning", 32'(running), 1);

        // Ping-pong.
        pulseRestart(2'b11);
        applyStimulus(40, "pingPong");

        // Loop down.
        pulseRestart(2'b01);
        checkOutput("loopDownStart", 32'(count), M - 1);
        applyStimulus(24, "loopDown");

        // Freeze mid-period and resume.
        mode  = 2'b00;
        guard = 0;
        while (mPre != 2 && guard < 10) begin
            tick("seekPre2");
            guard++;
        end
        if (guard == 10) checkOutput("seekPre2Timeout", 0, 1);
        frozen = count;
        enable = 1'b0;
        applyStimulus(10, "frozen");
        checkOutput("frozenCount", 32'(count), int'(frozen));
        enable = 1'b1;
        tick("resume1");
        checkOutput("resumeNoStep", 32'(step_tick), 0);
        tick("resume2");
        checkOutput("resumeStep", 32'(step_tick), 1);

        // Restart coincident with a step.
        guard = 0;
        while (!(mPre == CLK_DIV - 1 && mCount != 0) && guard < 40) begin
            tick("seekStepEdge");
            guard++;
        end
        if (guard == 40) checkOutput("seekStepEdgeTimeout", 0, 1);
        pulseRestart(2'b00);
        checkOutput("restartWinsCount", 32'(count),     0);
        checkOutput("restartWinsStep",  32'(step_tick), 0);

        // Asynchronous reset mid-period, restart ignored under reset.
        guard = 0;
        while (mCount != 3 && guard < 40) begin
            tick("seekCount3");
            guard++;
        end
        if (guard == 40) checkOutput("seekCount3Timeout", 0, 1);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncResetCount",   32'(count),   0);
        checkOutput("asyncResetRunning", 32'(running), 1);
        mode    = 2'b01;
        restart = 1'b1;
        applyStimulus(3, "heldReset");
        checkOutput("restartUnderReset", 32'(count), 0);
        restart = 1'b0;
        mode    = 2'b00;
        reset   = 1'b1;
        applyStimulus(8, "afterReset");

        // Random phase.
        for (int i = 0; i < 800; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            tick("random");
        end
        restart = 1'b0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/note_step_counter.md
Name: note_step_counter

Overview:
- Parametrised successor of the note-address counter used by the music-note player.
- Steps a note index through 0..M-1 at a programmable rate and drives the note ROM address plus sequencing strobes.
- Replaces the derived divided clock with an internal prescaler and clock enable, so the whole block runs in the single clk domain.
- Adds enable, restart, four sweep modes, and end-of-sequence and step strobes.

Parameters:
- N, 8, width of count.
- M, 149, number of steps; count range 0..M-1. Constraint: 2 <= M <= 2^N.
- CLK_DIV, 12500000, clk cycles per step (8 steps/s at 100 MHz). Constraint: CLK_DIV >= 1.
- PW, 24, prescaler width. Constraint: 2^PW >= CLK_DIV.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high = prescaler and count advance; low = freeze.
- mode  in  2  sweep mode: 00 loop up, 01 loop down, 10 one-shot up, 11 ping-pong.
- restart  in  1  synchronous pulse: restart the sequence.
- count  out  N  current note index.
- step_tick  out  1  one-cycle pulse on every count update.
- complete_tick  out  1  one-cycle pulse at end of sequence.
- running  out  1  high while the sequence is active.

Behaviour:
- Reset (reset=0, asynchronous): count=0, prescaler=0, dir=up, running=1, step_tick=0, complete_tick=0. All outputs are registered.
- Prescaler:
  - Counts 0..CLK_DIV-1 while enable=1 and running=1.
  - At CLK_DIV-1 it wraps to 0 and raises an internal step strobe. The first step occurs CLK_DIV enabled cycles after reset or restart.
  - When enable=0 or running=0, the prescaler holds its value.
- On step, count updates and step_tick=1 in the same clock edge, so step_tick is coincident with the first cycle of the new count.
- Mode 00 (loop up): count+1. At M-1, wrap to 0 and pulse complete_tick.
- Mode 01 (loop down): count-1. At 0, wrap to M-1 and pulse complete_tick.
- Mode 10 (one-shot up): count+1.
  - On the step reaching M-1: pulse complete_tick and set running=0.
  - count then holds at M-1 and step_tick stays 0 until restart or reset.
- Mode 11 (ping-pong): dir register.
  - dir up: count+1; at M-1, go to M-2 and set dir=down.
  - dir down: count-1; at 0, go to 1 and set dir=up.
  - complete_tick pulses on the step where count becomes 0.
  - M=2 toggles 0,1,0,1.
- restart:
  - Has priority over step and enable.
  - Next edge: count = M-1 if mode=01, else 0. Also prescaler=0, dir=up, running=1, step_tick=0, complete_tick=0.
  - Valid in all modes, including after one-shot completion.
- Mode change mid-run:
  - Takes effect at the next step from the current count; no reset of count.
  - Switching into 11 keeps the current dir. dir is only cleared by reset or restart.
  - Switching out of 10 while running=0 does not resume; restart is required.
- enable low mid-period: prescaler and count freeze. On re-enable, the prescaler continues from the held value (no lost or extra step).
- Width rule: all compares are against M-1 at N bits. count is never outside 0..M-1.
- No combinational path from inputs to outputs.

Test Plan:
Use N=4, M=5, CLK_DIV=4.
1. Release reset, enable=1, mode=00 -> count 0→1 after 4 cycles; sequence 0,1,2,3,4,0; complete_tick one cycle with count=0 at cycle 20; step_tick every 4 cycles.
2. mode=10, restart pulse -> count 0..4; at count=4: complete_tick=1 and running=0; count holds 4 for 40 cycles with no step_tick. Second restart -> count=0, running=1.
3. mode=11 -> sequence 0,1,2,3,4,3,2,1,0,1; complete_tick only on 1→0.
4. mode=01 after restart -> count=4, then 3,2,1,0,4; complete_tick on 0→4.
5. enable=0 for 10 cycles at prescaler=2 -> count frozen; next step exactly 2 enabled cycles after re-enable. restart and step in the same cycle -> restart wins.
6. Assert reset asynchronously mid-period (between edges) with count=3 -> outputs immediately 0, running=1; restart asserted under reset is ignored.
